// File: rtl/simt_stack_pkg.sv
//------------------------------------------------------------------------------
// Module  : simt_stack_pkg
// Brief   : Shared types and error codes for the per-warp SIMT reconvergence
//           stack. Also provides the default stack depth and SP error-code
//           macros when no other file has defined them.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef SIMT_STACK_DEPTH
`define SIMT_STACK_DEPTH 16
`endif

`ifndef KIANA_SP_ERR_SIMT_STACK_OVERFLOW
`define KIANA_SP_ERR_SIMT_STACK_OVERFLOW 32'h0000_0020
`endif

`ifndef KIANA_SP_ERR_SIMT_STACK_UNDERFLOW
`define KIANA_SP_ERR_SIMT_STACK_UNDERFLOW 32'h0000_0040
`endif

package simt_stack_pkg;

   // Command stream issued by the branch unit; codes 5..7 are reserved.
   typedef enum logic [2:0] {
      OP_BRANCH = 3'd0,
      OP_JUMP   = 3'd1,
      OP_FLUSH  = 3'd2,
      OP_POP    = 3'd3,
      OP_PUSH   = 3'd4
   } branch_op_t;

   // IDLE accepts commands; PUSH2 writes the second divergence entry.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_PUSH2 = 1'b1
   } stk_state_t;

   localparam logic [31:0] ERR_OVERFLOW  = `KIANA_SP_ERR_SIMT_STACK_OVERFLOW;
   localparam logic [31:0] ERR_UNDERFLOW = `KIANA_SP_ERR_SIMT_STACK_UNDERFLOW;

endpackage

`default_nettype wire

// File: rtl/simt_stack_mem.sv
//------------------------------------------------------------------------------
// Module  : simt_stack_mem
// Brief   : DEPTH-entry register file holding stack entries. One synchronous
//           write port, one combinational read port. Data is not reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simt_stack_mem #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the entry being pushed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/simt_stack.sv
//------------------------------------------------------------------------------
// Module  : simt_stack
// Brief   : Per-warp SIMT reconvergence stack. Executes BRANCH / JUMP / FLUSH /
//           POP / PUSH from the branch unit, tracks the active thread mask and
//           next fetch PC, and flags overflow/underflow as sticky error bits.
//           Optional macro KIANA_SIMT_STACK_AUTO_POP_EN: a JUMP to the top
//           entry's PC pops the stack, restoring that entry's mask.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simt_stack
   import simt_stack_pkg::*;
#(
   parameter int                  THREAD_NUM = 32,
   parameter int                  PC_WIDTH   = 32,
   parameter int                  DEPTH      = `SIMT_STACK_DEPTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  branch_op_t                   cmd_op,
   input  logic [PC_WIDTH-1:0]          cmd_pc,
   input  logic [PC_WIDTH-1:0]          cmd_npc,
   input  logic [PC_WIDTH-1:0]          cmd_rpc,
   input  logic [THREAD_NUM-1:0]        cmd_mask,
   output logic [THREAD_NUM-1:0]        active_mask,
   output logic [PC_WIDTH-1:0]          next_pc,
   output logic                         pc_valid,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic [31:0]                  err
);

   localparam int              DW        = $clog2(DEPTH + 1);
   localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              EW        = PC_WIDTH + THREAD_NUM;
   localparam logic [DW-1:0]   ONE       = DW'(1);
   localparam logic [DW-1:0]   FULL_LVL  = DW'(DEPTH);
   localparam logic [DW-1:0]   DIV_LIMIT = DW'(DEPTH - 2);

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [THREAD_NUM-1:0] mask;
   } entry_t;

   stk_state_t            state_q, state_d;
   logic [THREAD_NUM-1:0] mask_q, mask_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [DW-1:0]         depth_q, depth_d;
   logic [31:0]           err_q, err_d;
   logic                  pc_valid_q, pc_valid_d;
   logic [PC_WIDTH-1:0]   lat_npc_q, lat_npc_d;
   logic [THREAD_NUM-1:0] lat_nmask_q, lat_nmask_d;
   logic [PC_WIDTH-1:0]   lat_pc_q, lat_pc_d;
   logic [THREAD_NUM-1:0] lat_tmask_q, lat_tmask_d;

   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   entry_t                wr_data;
   logic [AW-1:0]         rd_addr;
   entry_t                top;
   logic [THREAD_NUM-1:0] t_mask;

   assign t_mask  = cmd_mask & mask_q;
   assign rd_addr = AW'(depth_q - ONE);

   simt_stack_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (top)
   );

   // Next-state, stack writes and error collection for the command in flight.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      pc_d        = pc_q;
      depth_d     = depth_q;
      err_d       = err_q;
      pc_valid_d  = 1'b0;
      lat_npc_d   = lat_npc_q;
      lat_nmask_d = lat_nmask_q;
      lat_pc_d    = lat_pc_q;
      lat_tmask_d = lat_tmask_q;
      wr_en       = 1'b0;
      wr_addr     = AW'(depth_q);
      wr_data     = '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_BRANCH: begin
                     if (t_mask == mask_q) begin
                        pc_d       = cmd_pc;
                        pc_valid_d = 1'b1;
                     end else if (t_mask == '0) begin
                        pc_d       = cmd_npc;
                        pc_valid_d = 1'b1;
                     end else if (depth_q > DIV_LIMIT) begin
                        // Two entries would not fit; refuse the whole branch.
                        err_d = err_q | ERR_OVERFLOW;
                     end else begin
                        wr_en        = 1'b1;
                        wr_data.pc   = cmd_rpc;
                        wr_data.mask = mask_q;
                        depth_d      = depth_q + ONE;
                        lat_npc_d    = cmd_npc;
                        lat_nmask_d  = mask_q & ~t_mask;
                        lat_pc_d     = cmd_pc;
                        lat_tmask_d  = t_mask;
                        state_d      = ST_PUSH2;
                     end
                  end
                  OP_JUMP: begin
`ifdef KIANA_SIMT_STACK_AUTO_POP_EN
                     if ((depth_q != '0) && (cmd_pc == top.pc)) begin
                        mask_d  = top.mask;
                        depth_d = depth_q - ONE;
                     end
`endif
                     pc_d       = cmd_pc;
                     pc_valid_d = 1'b1;
                  end
                  OP_FLUSH: begin
                     depth_d    = '0;
                     mask_d     = '1;
                     pc_d       = cmd_pc;
                     pc_valid_d = 1'b1;
                  end
                  OP_POP: begin
                     if (depth_q == '0) begin
                        err_d = err_q | ERR_UNDERFLOW;
                     end else begin
                        pc_d       = top.pc;
                        mask_d     = top.mask;
                        depth_d    = depth_q - ONE;
                        pc_valid_d = 1'b1;
                     end
                  end
                  OP_PUSH: begin
                     if (depth_q == FULL_LVL) begin
                        err_d = err_q | ERR_OVERFLOW;
                     end else begin
                        wr_en        = 1'b1;
                        wr_data.pc   = cmd_pc;
                        wr_data.mask = cmd_mask;
                        depth_d      = depth_q + ONE;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
         ST_PUSH2: begin
            wr_en        = 1'b1;
            wr_data.pc   = lat_npc_q;
            wr_data.mask = lat_nmask_q;
            depth_d      = depth_q + ONE;
            mask_d       = lat_tmask_q;
            pc_d         = lat_pc_q;
            pc_valid_d   = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset abandons any half-finished divergence push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mask_q      <= '1;
         pc_q        <= RESET_PC;
         depth_q     <= '0;
         err_q       <= '0;
         pc_valid_q  <= 1'b0;
         lat_npc_q   <= '0;
         lat_nmask_q <= '0;
         lat_pc_q    <= '0;
         lat_tmask_q <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         pc_q        <= pc_d;
         depth_q     <= depth_d;
         err_q       <= err_d;
         pc_valid_q  <= pc_valid_d;
         lat_npc_q   <= lat_npc_d;
         lat_nmask_q <= lat_nmask_d;
         lat_pc_q    <= lat_pc_d;
         lat_tmask_q <= lat_tmask_d;
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign active_mask = mask_q;
   assign next_pc     = pc_q;
   assign pc_valid    = pc_valid_q;
   assign depth       = depth_q;
   assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_simt_stack.sv
//------------------------------------------------------------------------------
// Module  : tb_simt_stack
// Brief   : Self-checking bench for simt_stack: directed scenarios plus random
//           command streams compared against a queue-based stack model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_simt_stack;
   import simt_stack_pkg::*;

   localparam int DEP = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   branch_op_t  cmd_op = OP_JUMP;
   logic [31:0] cmd_pc = '0;
   logic [31:0] cmd_npc = '0;
   logic [31:0] cmd_rpc = '0;
   logic [31:0] cmd_mask = '0;
   logic [31:0] active_mask;
   logic [31:0] next_pc;
   logic        pc_valid;
   logic [4:0]  depth;
   logic [31:0] err;

   int total = 0;
   int bad   = 0;

   simt_stack #(
      .THREAD_NUM (32),
      .PC_WIDTH   (32),
      .DEPTH      (DEP),
      .RESET_PC   (32'h0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_pc      (cmd_pc),
      .cmd_npc     (cmd_npc),
      .cmd_rpc     (cmd_rpc),
      .cmd_mask    (cmd_mask),
      .active_mask (active_mask),
      .next_pc     (next_pc),
      .pc_valid    (pc_valid),
      .depth       (depth),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of {pc, mask} plus the warp's live state.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] mask;
   } ent_t;

   ent_t        stk[$];
   logic [31:0] m_mask;
   logic [31:0] m_pc;
   logic [31:0] m_err;
   logic        m_pv;
   logic        m_two;
   logic        mid_ready;

   task automatic model_reset();
      stk.delete();
      m_mask = 32'hFFFF_FFFF;
      m_pc   = 32'h0;
      m_err  = 32'h0;
      m_pv   = 1'b0;
      m_two  = 1'b0;
   endtask

   task automatic model_apply(input branch_op_t op, input logic [31:0] pc,
                              input logic [31:0] npc, input logic [31:0] rpc,
                              input logic [31:0] msk);
      logic [31:0] t;
      ent_t        e;
      m_pv  = 1'b0;
      m_two = 1'b0;
      case (op)
         OP_BRANCH: begin
            t = msk & m_mask;
            if (t == m_mask) begin
               m_pc = pc; m_pv = 1'b1;
            end else if (t == 32'h0) begin
               m_pc = npc; m_pv = 1'b1;
            end else if (stk.size() + 2 > DEP) begin
               m_err = m_err | 32'h20;
            end else begin
               e.pc = rpc; e.mask = m_mask;      stk.push_back(e);
               e.pc = npc; e.mask = m_mask & ~t; stk.push_back(e);
               m_mask = t; m_pc = pc; m_pv = 1'b1; m_two = 1'b1;
            end
         end
         OP_JUMP: begin
`ifdef KIANA_SIMT_STACK_AUTO_POP_EN
            if (stk.size() > 0 && stk[$].pc == pc) begin
               e = stk.pop_back();
               m_mask = e.mask;
            end
`endif
            m_pc = pc; m_pv = 1'b1;
         end
         OP_FLUSH: begin
            stk.delete(); m_mask = 32'hFFFF_FFFF; m_pc = pc; m_pv = 1'b1;
         end
         OP_POP: begin
            if (stk.size() == 0) begin
               m_err = m_err | 32'h40;
            end else begin
               e = stk.pop_back();
               m_pc = e.pc; m_mask = e.mask; m_pv = 1'b1;
            end
         end
         OP_PUSH: begin
            if (stk.size() == DEP) begin
               m_err = m_err | 32'h20;
            end else begin
               e.pc = pc; e.mask = msk; stk.push_back(e);
            end
         end
         default: begin
         end
      endcase
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Issue one command; returns once its full effect is visible.
   task automatic do_cmd(input branch_op_t op, input logic [31:0] pc,
                         input logic [31:0] npc, input logic [31:0] rpc,
                         input logic [31:0] msk);
      int guard = 0;
      while (cmd_ready !== 1'b1 && guard < 8) begin
         @(posedge clk); #1; guard++;
      end
      if (cmd_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL ready_timeout: got %b want 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_pc = pc; cmd_npc = npc;
      cmd_rpc = rpc; cmd_mask = msk;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      model_apply(op, pc, npc, rpc, msk);
      mid_ready = cmd_ready;
      if (m_two) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total += 6;
      if (active_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_mask: got %h want ffffffff", active_mask); end
      if (next_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", next_pc); end
      if (depth !== 5'd0) begin bad++; $display("FAIL reset_depth: got %0d want 0", depth); end
      if (err !== 32'h0) begin bad++; $display("FAIL reset_err: got %h want 0", err); end
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
      if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset_pcvalid: got %b want 0", pc_valid); end
   endtask

   task automatic test_divergent();
      do_reset();
      do_cmd(OP_BRANCH, 32'h100, 32'h80, 32'h200, 32'h0000_FFFF);
      total += 6;
      if (mid_ready !== 1'b0) begin bad++; $display("FAIL div_ready_low: got %b want 0", mid_ready); end
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL div_ready_back: got %b want 1", cmd_ready); end
      if (active_mask !== 32'h0000_FFFF) begin bad++; $display("FAIL div_mask: got %h want 0000ffff", active_mask); end
      if (next_pc !== 32'h100) begin bad++; $display("FAIL div_pc: got %h want 100", next_pc); end
      if (depth !== 5'd2) begin bad++; $display("FAIL div_depth: got %0d want 2", depth); end
      if (pc_valid !== 1'b1) begin bad++; $display("FAIL div_pcvalid: got %b want 1", pc_valid); end
      @(posedge clk); #1;
      total++;
      if (pc_valid !== 1'b0) begin bad++; $display("FAIL div_pulse_width: got %b want 0", pc_valid); end
      do_cmd(OP_POP, 32'h0, 32'h0, 32'h0, 32'h0);
      total += 4;
      if (active_mask !== 32'hFFFF_0000) begin bad++; $display("FAIL pop1_mask: got %h want ffff0000", active_mask); end
      if (next_pc !== 32'h80) begin bad++; $display("FAIL pop1_pc: got %h want 80", next_pc); end
      if (depth !== 5'd1) begin bad++; $display("FAIL pop1_depth: got %0d want 1", depth); end
      if (pc_valid !== 1'b1) begin bad++; $display("FAIL pop1_pcvalid: got %b want 1", pc_valid); end
      do_cmd(OP_POP, 32'h0, 32'h0, 32'h0, 32'h0);
      total += 3;
      if (active_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL pop2_mask: got %h want ffffffff", active_mask); end
      if (next_pc !== 32'h200) begin bad++; $display("FAIL pop2_pc: got %h want 200", next_pc); end
      if (depth !== 5'd0) begin bad++; $display("FAIL pop2_depth: got %0d want 0", depth); end
   endtask

   task automatic test_uniform();
      do_reset();
      do_cmd(OP_BRANCH, 32'h300, 32'h304, 32'h400, 32'hFFFF_FFFF);
      total += 3;
      if (next_pc !== 32'h300) begin bad++; $display("FAIL uni_taken_pc: got %h want 300", next_pc); end
      if (depth !== 5'd0) begin bad++; $display("FAIL uni_taken_depth: got %0d want 0", depth); end
      if (pc_valid !== 1'b1) begin bad++; $display("FAIL uni_taken_pcvalid: got %b want 1", pc_valid); end
      do_cmd(OP_BRANCH, 32'h500, 32'h504, 32'h600, 32'h0);
      total += 3;
      if (next_pc !== 32'h504) begin bad++; $display("FAIL uni_not_pc: got %h want 504", next_pc); end
      if (depth !== 5'd0) begin bad++; $display("FAIL uni_not_depth: got %0d want 0", depth); end
      if (active_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL uni_not_mask: got %h want ffffffff", active_mask); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEP; i++) do_cmd(OP_PUSH, 32'(i * 4), 32'h0, 32'h0, $urandom);
      total += 2;
      if (depth !== 5'd16) begin bad++; $display("FAIL ovf_full_depth: got %0d want 16", depth); end
      if (err !== 32'h0) begin bad++; $display("FAIL ovf_full_err: got %h want 0", err); end
      do_cmd(OP_PUSH, 32'hABC, 32'h0, 32'h0, 32'h1);
      total += 3;
      if (err !== 32'h20) begin bad++; $display("FAIL ovf_push_err: got %h want 20", err); end
      if (depth !== 5'd16) begin bad++; $display("FAIL ovf_push_depth: got %0d want 16", depth); end
      if (pc_valid !== 1'b0) begin bad++; $display("FAIL ovf_push_pcvalid: got %b want 0", pc_valid); end
      do_reset();
      for (int i = 0; i < DEP - 1; i++) do_cmd(OP_PUSH, 32'(i * 8), 32'h0, 32'h0, $urandom);
      do_cmd(OP_BRANCH, 32'h100, 32'h80, 32'h200, 32'h0000_FFFF);
      total += 5;
      if (err !== 32'h20) begin bad++; $display("FAIL ovf_br_err: got %h want 20", err); end
      if (depth !== 5'd15) begin bad++; $display("FAIL ovf_br_depth: got %0d want 15", depth); end
      if (active_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ovf_br_mask: got %h want ffffffff", active_mask); end
      if (pc_valid !== 1'b0) begin bad++; $display("FAIL ovf_br_pcvalid: got %b want 0", pc_valid); end
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ovf_br_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_underflow_flush();
      do_reset();
      do_cmd(OP_POP, 32'h0, 32'h0, 32'h0, 32'h0);
      total += 3;
      if (err !== 32'h40) begin bad++; $display("FAIL udf_err: got %h want 40", err); end
      if (pc_valid !== 1'b0) begin bad++; $display("FAIL udf_pcvalid: got %b want 0", pc_valid); end
      if (depth !== 5'd0) begin bad++; $display("FAIL udf_depth: got %0d want 0", depth); end
      for (int i = 0; i < 5; i++) do_cmd(OP_PUSH, 32'h40 + 32'(i), 32'h0, 32'h0, 32'h0000_00FF);
      do_cmd(OP_BRANCH, 32'h700, 32'h704, 32'h800, 32'h0000_000F);
      do_cmd(OP_POP, 32'h0, 32'h0, 32'h0, 32'h0);
      do_cmd(OP_POP, 32'h0, 32'h0, 32'h0, 32'h0);
      total++;
      if (depth !== 5'd5) begin bad++; $display("FAIL flush_pre_depth: got %0d want 5", depth); end
      do_cmd(OP_FLUSH, 32'h400, 32'h0, 32'h0, 32'h0);
      total += 4;
      if (depth !== 5'd0) begin bad++; $display("FAIL flush_depth: got %0d want 0", depth); end
      if (active_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_mask: got %h want ffffffff", active_mask); end
      if (next_pc !== 32'h400) begin bad++; $display("FAIL flush_pc: got %h want 400", next_pc); end
      if (err !== 32'h40) begin bad++; $display("FAIL flush_err: got %h want 40", err); end
   endtask

   task automatic test_auto_pop();
      do_reset();
      do_cmd(OP_BRANCH, 32'h100, 32'h80, 32'h200, 32'h0000_FFFF);
      do_cmd(OP_JUMP, 32'h80, 32'h0, 32'h0, 32'h0);
      total += 3;
      if (next_pc !== 32'h80) begin bad++; $display("FAIL jump_pc: got %h want 80", next_pc); end
`ifdef KIANA_SIMT_STACK_AUTO_POP_EN
      if (active_mask !== 32'hFFFF_0000) begin bad++; $display("FAIL autopop_mask: got %h want ffff0000", active_mask); end
      if (depth !== 5'd1) begin bad++; $display("FAIL autopop_depth: got %0d want 1", depth); end
`else
      if (active_mask !== 32'h0000_FFFF) begin bad++; $display("FAIL jump_mask: got %h want 0000ffff", active_mask); end
      if (depth !== 5'd2) begin bad++; $display("FAIL jump_depth: got %0d want 2", depth); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      cmd_valid = 1'b1; cmd_op = OP_BRANCH; cmd_pc = 32'h100; cmd_npc = 32'h80;
      cmd_rpc = 32'h200; cmd_mask = 32'h0000_FFFF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_in_push2: got %b want 0", cmd_ready); end
      #2 rst_n = 1'b0;
      #1;
      total += 6;
      if (active_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_mask: got %h want ffffffff", active_mask); end
      if (next_pc !== 32'h0) begin bad++; $display("FAIL mid_pc: got %h want 0", next_pc); end
      if (depth !== 5'd0) begin bad++; $display("FAIL mid_depth: got %0d want 0", depth); end
      if (err !== 32'h0) begin bad++; $display("FAIL mid_err: got %h want 0", err); end
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
      if (pc_valid !== 1'b0) begin bad++; $display("FAIL mid_pcvalid: got %b want 0", pc_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      do_cmd(OP_POP, 32'h0, 32'h0, 32'h0, 32'h0);
      total += 2;
      if (err !== 32'h40) begin bad++; $display("FAIL mid_discard_err: got %h want 40", err); end
      if (depth !== 5'd0) begin bad++; $display("FAIL mid_discard_depth: got %0d want 0", depth); end
   endtask

   task automatic test_random();
      branch_op_t  op;
      logic [31:0] pc, npc, rpc, msk;
      int          r;
      do_reset();
      for (int it = 0; it < 400; it++) begin
         r   = $urandom_range(0, 99);
         pc  = $urandom & 32'h0000_FFFC;
         npc = $urandom & 32'h0000_FFFC;
         rpc = $urandom & 32'h0000_FFFC;
         msk = $urandom;
         if (r < 35) begin
            op = OP_BRANCH;
            case ($urandom_range(0, 3))
               0: msk = m_mask | msk;
               1: msk = ~m_mask & msk;
               default: begin end
            endcase
         end else if (r < 50) begin
            op = OP_JUMP;
            if (stk.size() > 0 && $urandom_range(0, 1) == 1) pc = stk[$].pc;
         end else if (r < 72) op = OP_POP;
         else if (r < 92) op = OP_PUSH;
         else if (r < 95) op = OP_FLUSH;
         else op = branch_op_t'(3'(5 + $urandom_range(0, 2)));
         do_cmd(op, pc, npc, rpc, msk);
         total += 6;
         if (active_mask !== m_mask) begin bad++; $display("FAIL rnd_mask it=%0d: got %h want %h", it, active_mask, m_mask); end
         if (next_pc !== m_pc) begin bad++; $display("FAIL rnd_pc it=%0d: got %h want %h", it, next_pc, m_pc); end
         if (depth !== 5'(stk.size())) begin bad++; $display("FAIL rnd_depth it=%0d: got %0d want %0d", it, depth, stk.size()); end
         if (err !== m_err) begin bad++; $display("FAIL rnd_err it=%0d: got %h want %h", it, err, m_err); end
         if (pc_valid !== m_pv) begin bad++; $display("FAIL rnd_pcvalid it=%0d: got %b want %b", it, pc_valid, m_pv); end
         if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready it=%0d: got %b want 1", it, cmd_ready); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_divergent();
      test_uniform();
      test_overflow();
      test_underflow_flush();
      test_auto_pop();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/simt_stack.md
# simt_stack

Per-warp SIMT reconvergence stack: the responder side of the `branch_op_t` command stream (BRANCH, JUMP, FLUSH, POP, PUSH) issued by the branch unit. It holds the warp's active thread mask and next PC. It pushes divergence and reconvergence entries, restores masks on POP, and reports overflow and underflow through the shared SP error-code vector. It sits between the branch unit and the fetcher, one instance per warp.

## Interface
- `THREAD_NUM`, default 32: threads per warp; the mask width.
- `PC_WIDTH`, default 32: PC width.
- `DEPTH`, default `` `SIMT_STACK_DEPTH `` (16): number of stack entries.
- `RESET_PC`, default 0: PC loaded at reset.
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command can be accepted.
- `cmd_op` input `branch_op_t`: operation.
- `cmd_pc` input `PC_WIDTH`: branch, jump or flush target, or PUSH PC.
- `cmd_npc` input `PC_WIDTH`: fall-through PC (BRANCH only).
- `cmd_rpc` input `PC_WIDTH`: reconvergence PC (BRANCH only).
- `cmd_mask` input `THREAD_NUM`: taken mask (BRANCH) or pushed mask (PUSH).
- `active_mask` output `THREAD_NUM`: current active threads.
- `next_pc` output `PC_WIDTH`: PC the fetcher uses next.
- `pc_valid` output 1: one-cycle pulse when `next_pc` or `active_mask` changes.
- `depth` output `$clog2(DEPTH+1)`: current number of stack entries.
- `err` output 32: sticky error bits using the SP error-code encoding.

## Operation
- A command is accepted when `cmd_valid && cmd_ready`.
- In the rules below, `M` is `active_mask` and `T` is `cmd_mask & M`.
- **BRANCH, uniform taken** (`T == M`): `next_pc <= cmd_pc`; the stack is unchanged.
- **BRANCH, uniform not taken** (`T == 0`): `next_pc <= cmd_npc`; the stack is unchanged.
- **BRANCH, divergent:**
  - If `depth > DEPTH-2`, set the OVERFLOW bit. Nothing else changes and `pc_valid` stays 0.
  - Otherwise, in the accept cycle push `{cmd_rpc, M}` and latch `cmd_npc`, `M & ~T`, `cmd_pc` and `T`.
  - Then enter state `PUSH2`. There, push `{npc, M & ~T}`, set `active_mask <= T` and `next_pc <= cmd_pc`, and return to `IDLE`.
- **JUMP:** `next_pc <= cmd_pc`; the mask is unchanged.
- **PUSH:** push `{cmd_pc, cmd_mask}`. The active state is unchanged and `pc_valid` stays 0. If the stack is full, set OVERFLOW and drop the push.
- **POP:** `{next_pc, active_mask} <= top`, then `depth--`. If the stack is empty, set UNDERFLOW; no state changes and there is no `pc_valid` pulse.
- **FLUSH:** `depth <= 0`, `active_mask <= all ones`, `next_pc <= cmd_pc`. FLUSH does not clear `err`.
- The FSM has two states:
  - `IDLE` goes to `PUSH2` on an accepted, non-overflowing divergent BRANCH. Otherwise it stays in `IDLE`.
  - `PUSH2` returns to `IDLE` unconditionally.
- `err` bits are sticky until reset.
- Any `cmd_op` encoding outside the five defined values is ignored, with no state change.

## Timing
- **Reset values:** `active_mask` all ones, `next_pc = RESET_PC`, `depth = 0`, `err = 0`, `pc_valid = 0`, state `IDLE`, `cmd_ready = 1`.
- `cmd_ready = (state == IDLE)`. It is registered-state-derived, with no combinational path from `cmd_valid`.
- **Latency, single-cycle commands:** outputs update on the clock edge that accepts the command. `pc_valid` is high in the following cycle.
- **Latency, divergent BRANCH:** `cmd_ready` is low for exactly 1 cycle. The new mask and PC appear after the second edge, with `pc_valid` high for one cycle.
- **Entry storage:** indexed by `depth`; there is no wrap-around. Full means `depth == DEPTH`; empty means `depth == 0`.
- **Reset mid-operation:** asserting `rst_n` low in `PUSH2` aborts the operation. All state returns to reset values and the half-pushed entry is discarded.

## Configuration
- Macro: `KIANA_SIMT_STACK_AUTO_POP_EN`.
- **Defined:** an accepted JUMP whose `cmd_pc` equals the top entry's PC (with `depth > 0`) is executed as a POP. The mask is restored from the top entry, so reconvergence needs no explicit POP.
- **Undefined:** JUMP never touches the stack.

## Structure
- Add to the `common` package:
  - `` `KIANA_SP_ERR_SIMT_STACK_OVERFLOW `` = `32'h0000_0020`.
  - `` `KIANA_SP_ERR_SIMT_STACK_UNDERFLOW `` = `32'h0000_0040`.
  - The entry typedef is parameterised by width, so define it locally as a packed struct `{pc, mask}`.
- Sub-module `simt_stack_mem`: an `DEPTH`-entry register file with one write port and one read port (top of stack, combinational read), no reset on data.

## Test plan
- **Reset:** hold `rst_n` low, then release. Expect `active_mask = 32'hFFFF_FFFF`, `next_pc = 0`, `depth = 0`, `err = 0`, `cmd_ready = 1`.
- **Divergent BRANCH then POPs:**
  - Stimulus: BRANCH with `cmd_pc = 0x100`, `cmd_npc = 0x80`, `cmd_rpc = 0x200`, `cmd_mask = 0x0000_FFFF`.
  - Expect `cmd_ready` low for 1 cycle, then `active_mask = 0x0000_FFFF`, `next_pc = 0x100`, `depth = 2`.
  - First POP: expect `0xFFFF_0000` / `0x80`.
  - Second POP: expect `0xFFFF_FFFF` / `0x200`, `depth = 0`.
- **Uniform branches:** BRANCH with `cmd_mask = 0xFFFF_FFFF` gives `next_pc = cmd_pc`; with `cmd_mask = 0` gives `next_pc = cmd_npc`. `depth` stays 0 in both cases.
- **Overflow:**
  - 16 PUSHes, then a 17th. Expect `err = 0x20`, `depth = 16`.
  - Separately, at `depth = 15` issue a divergent BRANCH. Expect `err = 0x20`, `depth = 15`, mask unchanged.
- **Underflow and FLUSH:**
  - POP at `depth = 0`: expect `err = 0x40` and no `pc_valid` pulse.
  - FLUSH `0x400` at `depth = 5`: expect `depth = 0`, mask all ones, `next_pc = 0x400`, `err` still set.
- **Auto-pop (macro defined) and reset mid-operation:**
  - After a divergent BRANCH with `cmd_rpc = 0x200`, a JUMP to `0x80` (the top entry's PC) pops, and the mask restores to `0xFFFF_0000`.
  - Asserting `rst_n` low during `PUSH2` restores all reset values.
